mem_stage: RTL and testbench

Load/store pipeline stage directly downstream of the ALU in the RISC-V core. It consumes the registered ALU result as either a data-memory address or a pass-through writeback value. It runs a request/acknowledge transaction with data memory for loads and stores, handling byte lanes and sign/zero extension. It presents one writeback record per accepted instruction, and asserts `stall_out` to freeze upstream stages while a memory access is outstanding.

---
 rtl/mem_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Load/store stage: request/ack data-memory access, byte lanes, load extension, writeback record.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses trap instead of being force-aligned.
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [3:0]  ex_mem_op,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        misalign_fault
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 4;
  localparam int unsigned RW   = 5;

  localparam logic [OPW-1:0] OP_LB  = 4'b0001;
  localparam logic [OPW-1:0] OP_LH  = 4'b0010;
  localparam logic [OPW-1:0] OP_LW  = 4'b0011;
  localparam logic [OPW-1:0] OP_LBU = 4'b0100;
  localparam logic [OPW-1:0] OP_LHU = 4'b0101;
  localparam logic [OPW-1:0] OP_SB  = 4'b1000;
  localparam logic [OPW-1:0] OP_SH  = 4'b1001;
  localparam logic [OPW-1:0] OP_SW  = 4'b1010;

  typedef enum logic [0:0] {IDLE, WAIT} state_t;

  state_t            state, state_nx;
  logic              req_nx, we_nx, wb_valid_nx, wb_rw_nx;
  logic [XLEN-1:0]   addr_nx, wdata_nx, wb_data_nx;
  logic [3:0]        be_nx;
  logic [RW-1:0]     wb_rd_nx, rd_q, rd_nx;
  logic [OPW-1:0]    op_q, op_nx;
  logic [1:0]        off_q, off_nx;
  logic              rw_q, rw_nx;

  // Opcode decode and effective (force-aligned) address
  logic            is_load, is_store, is_mem, sz_byte, sz_half;
  logic [XLEN-1:0] eff_addr;
  logic [3:0]      be_calc;
  logic [XLEN-1:0] wdata_calc;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sz_byte  = 1'b0;
    sz_half  = 1'b0;
    case (ex_mem_op)
      OP_LB, OP_LBU: begin is_load = 1'b1;  sz_byte = 1'b1; end
      OP_LH, OP_LHU: begin is_load = 1'b1;  sz_half = 1'b1; end
      OP_LW:         is_load = 1'b1;
      OP_SB:         begin is_store = 1'b1; sz_byte = 1'b1; end
      OP_SH:         begin is_store = 1'b1; sz_half = 1'b1; end
      OP_SW:         is_store = 1'b1;
      default: ;
    endcase
    is_mem   = is_load | is_store;
    eff_addr = ex_alu_result;
    if (sz_half)                 eff_addr[0]   = 1'b0;
    else if (!sz_byte)           eff_addr[1:0] = 2'b00;
    if (sz_byte) begin
      be_calc    = 4'b0001 << eff_addr[1:0];
      wdata_calc = {4{ex_store_data[7:0]}};
    end else if (sz_half) begin
      be_calc    = 4'b0011 << eff_addr[1:0];
      wdata_calc = {2{ex_store_data[15:0]}};
    end else begin
      be_calc    = 4'b1111;
      wdata_calc = ex_store_data;
    end
  end

  // Load lane extraction and extension from the captured offset
  logic [XLEN-1:0] shifted, load_val;
  always_comb begin
    shifted = dmem_rdata >> {off_q, 3'b000};
    case (op_q)
      OP_LB:   load_val = {{24{shifted[7]}}, shifted[7:0]};
      OP_LH:   load_val = {{16{shifted[15]}}, shifted[15:0]};
      OP_LBU:  load_val = {24'd0, shifted[7:0]};
      OP_LHU:  load_val = {16'd0, shifted[15:0]};
      default: load_val = dmem_rdata;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned, fault_nx;
  assign misaligned = (sz_half & ex_alu_result[0]) |
                      (is_mem & ~sz_byte & ~sz_half & (ex_alu_result[1:0] != 2'b00));
`endif

  always_comb begin
    state_nx    = state;
    req_nx      = dmem_req;
    we_nx       = dmem_we;
    addr_nx     = dmem_addr;
    be_nx       = dmem_be;
    wdata_nx    = dmem_wdata;
    wb_valid_nx = wb_valid;
    wb_data_nx  = wb_data;
    wb_rd_nx    = wb_rd;
    wb_rw_nx    = wb_reg_write;
    op_nx       = op_q;
    rd_nx       = rd_q;
    rw_nx       = rw_q;
    off_nx      = off_q;
`ifdef MEM_MISALIGN_TRAP_EN
    fault_nx    = misalign_fault;
`endif
    if (!halt) begin
`ifdef MEM_MISALIGN_TRAP_EN
      fault_nx = 1'b0;
`endif
      case (state)
        IDLE: begin
          wb_valid_nx = 1'b0;
          if (ex_valid) begin
            if (!is_mem) begin
              wb_valid_nx = 1'b1;
              wb_data_nx  = ex_alu_result;
              wb_rd_nx    = ex_rd;
              wb_rw_nx    = ex_reg_write;
            end
`ifdef MEM_MISALIGN_TRAP_EN
            else if (misaligned) begin
              wb_valid_nx = 1'b1;
              wb_data_nx  = '0;
              wb_rd_nx    = ex_rd;
              wb_rw_nx    = 1'b0;
              fault_nx    = 1'b1;
            end
`endif
            else begin
              req_nx   = 1'b1;
              we_nx    = is_store;
              addr_nx  = {eff_addr[XLEN-1:2], 2'b00};
              be_nx    = be_calc;
              wdata_nx = wdata_calc;
              op_nx    = ex_mem_op;
              rd_nx    = ex_rd;
              rw_nx    = ex_reg_write;
              off_nx   = eff_addr[1:0];
              state_nx = WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            req_nx      = 1'b0;
            state_nx    = IDLE;
            wb_valid_nx = 1'b1;
            wb_rd_nx    = rd_q;
            wb_rw_nx    = dmem_we ? 1'b0 : rw_q;
            wb_data_nx  = dmem_we ? '0 : load_val;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      op_q         <= '0;
      rd_q         <= '0;
      rw_q         <= 1'b0;
      off_q        <= '0;
    end else begin
      state        <= state_nx;
      dmem_req     <= req_nx;
      dmem_we      <= we_nx;
      dmem_addr    <= addr_nx;
      dmem_be      <= be_nx;
      dmem_wdata   <= wdata_nx;
      wb_valid     <= wb_valid_nx;
      wb_data      <= wb_data_nx;
      wb_rd        <= wb_rd_nx;
      wb_reg_write <= wb_rw_nx;
      op_q         <= op_nx;
      rd_q         <= rd_nx;
      rw_q         <= rw_nx;
      off_q        <= off_nx;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_fault <= 1'b0;
    else        misalign_fault <= fault_nx;
  end
`else
  assign misalign_fault = 1'b0;
`endif

  assign stall_out = (state == WAIT);

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores, misalignment, halt, reset.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n, halt, ex_valid, ex_reg_write, dmem_ack;
  logic [31:0] ex_alu_result, ex_store_data, dmem_rdata;
  logic [3:0]  ex_mem_op;
  logic [4:0]  ex_rd;
  logic        stall_out, dmem_req, dmem_we, wb_valid, wb_reg_write, misalign_fault;
  logic [31:0] dmem_addr, dmem_wdata, wb_data;
  logic [3:0]  dmem_be;
  logic [4:0]  wb_rd;
  int          vecs = 0;
  int          errs = 0;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .ex_valid(ex_valid),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_mem_op(ex_mem_op),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .stall_out(stall_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .misalign_fault(misalign_fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd, input logic rw);
    ex_valid = 1'b1; ex_mem_op = op; ex_alu_result = a; ex_store_data = d;
    ex_rd = rd; ex_reg_write = rw;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; halt = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0; ex_valid = 1'b0;
    ex_mem_op = '0; ex_alu_result = '0; ex_store_data = '0; ex_rd = '0; ex_reg_write = 1'b0;
    tick(); tick();
    vecs++; if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== 70'd0) begin errs++; $display("FAIL reset_dmem got req=%b we=%b addr=%h be=%b wdata=%h want all 0", dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata); end
    vecs++; if ({wb_valid, wb_data, wb_rd, wb_reg_write, misalign_fault, stall_out} !== 41'd0) begin errs++; $display("FAIL reset_wb got v=%b d=%h rd=%h rw=%b mf=%b st=%b want all 0", wb_valid, wb_data, wb_rd, wb_reg_write, misalign_fault, stall_out); end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_add();
    issue(4'b0000, 32'h0000_1234, '0, 5'd5, 1'b1);
    tick();
    vecs++; if ({wb_valid, wb_data, wb_rd, wb_reg_write, dmem_req} !== {1'b1, 32'h1234, 5'd5, 1'b1, 1'b0}) begin errs++; $display("FAIL add_wb got v=%b d=%h rd=%0d rw=%b req=%b want 1 00001234 5 1 0", wb_valid, wb_data, wb_rd, wb_reg_write, dmem_req); end
    issue(4'b0110, 32'h0000_0055, '0, 5'd6, 1'b1);
    tick();
    vecs++; if ({wb_valid, wb_data, wb_rd, stall_out} !== {1'b1, 32'h55, 5'd6, 1'b0}) begin errs++; $display("FAIL add_b2b got v=%b d=%h rd=%0d st=%b want 1 00000055 6 0", wb_valid, wb_data, wb_rd, stall_out); end
    ex_valid = 1'b0;
    tick();
    vecs++; if (wb_valid !== 1'b0) begin errs++; $display("FAIL add_idle got %b want 0", wb_valid); end
  endtask

  task automatic test_lb_wait();
    issue(4'b0001, 32'h0000_0103, '0, 5'd7, 1'b1);
    tick();
    ex_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vecs++; if ({dmem_req, dmem_we, dmem_addr, dmem_be, stall_out, wb_valid} !== {1'b1, 1'b0, 32'h100, 4'b1000, 1'b1, 1'b0}) begin errs++; $display("FAIL lb_wait%0d got req=%b we=%b addr=%h be=%b st=%b v=%b want 1 0 00000100 1000 1 0", i, dmem_req, dmem_we, dmem_addr, dmem_be, stall_out, wb_valid); end
      if (i < 2) tick();
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h80FF_0000;
    tick();
    dmem_ack = 1'b0;
    vecs++; if ({wb_valid, wb_data, wb_rd, wb_reg_write, stall_out, dmem_req} !== {1'b1, 32'hFFFF_FF80, 5'd7, 1'b1, 1'b0, 1'b0}) begin errs++; $display("FAIL lb_done got v=%b d=%h rd=%0d rw=%b st=%b req=%b want 1 ffffff80 7 1 0 0", wb_valid, wb_data, wb_rd, wb_reg_write, stall_out, dmem_req); end
    tick();
    vecs++; if (wb_valid !== 1'b0) begin errs++; $display("FAIL lb_pulse got %b want 0", wb_valid); end
  endtask

  task automatic test_lhu_zero_wait();
    issue(4'b0101, 32'h0000_0102, '0, 5'd8, 1'b1);
    dmem_ack = 1'b1; dmem_rdata = 32'h8001_0000;
    tick();
    ex_valid = 1'b0;
    vecs++; if ({dmem_req, stall_out, dmem_addr, dmem_be, wb_valid} !== {1'b1, 1'b1, 32'h100, 4'b1100, 1'b0}) begin errs++; $display("FAIL lhu_req got req=%b st=%b addr=%h be=%b v=%b want 1 1 00000100 1100 0", dmem_req, stall_out, dmem_addr, dmem_be, wb_valid); end
    tick();
    dmem_ack = 1'b0;
    vecs++; if ({wb_valid, wb_data, stall_out} !== {1'b1, 32'h0000_8001, 1'b0}) begin errs++; $display("FAIL lhu_done got v=%b d=%h st=%b want 1 00008001 0", wb_valid, wb_data, stall_out); end
  endtask

  task automatic test_load_ext();
    logic [3:0]  ops [4] = '{4'b0010, 4'b0100, 4'b0001, 4'b0011};
    logic [31:0] adr [4] = '{32'h2, 32'h1, 32'h0, 32'h4};
    logic [31:0] rdt [4] = '{32'h8001_0000, 32'h0000_F000, 32'h0000_007F, 32'h89AB_CDEF};
    logic [31:0] exp [4] = '{32'hFFFF_8001, 32'h0000_00F0, 32'h0000_007F, 32'h89AB_CDEF};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], adr[i], '0, 5'd9, 1'b1);
      tick();
      ex_valid = 1'b0; dmem_ack = 1'b1; dmem_rdata = rdt[i];
      tick();
      dmem_ack = 1'b0;
      vecs++; if ({wb_valid, wb_data} !== {1'b1, exp[i]}) begin errs++; $display("FAIL ld_ext%0d got v=%b d=%h want 1 %h", i, wb_valid, wb_data, exp[i]); end
    end
  endtask

  task automatic test_sb();
    issue(4'b1000, 32'h0000_0201, 32'h0000_00AB, 5'd3, 1'b1);
    tick();
    ex_valid = 1'b0;
    vecs++; if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !== {1'b1, 1'b1, 32'h200, 4'b0010, 32'hABAB_ABAB}) begin errs++; $display("FAIL sb_req got req=%b we=%b addr=%h be=%b wd=%h want 1 1 00000200 0010 abababab", dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata); end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    vecs++; if ({wb_valid, wb_reg_write, wb_data} !== {1'b1, 1'b0, 32'h0}) begin errs++; $display("FAIL sb_wb got v=%b rw=%b d=%h want 1 0 00000000", wb_valid, wb_reg_write, wb_data); end
  endtask

  task automatic test_misalign();
    issue(4'b0011, 32'h0000_0102, '0, 5'd4, 1'b1);
    tick();
    ex_valid = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    vecs++; if ({misalign_fault, wb_valid, wb_reg_write, dmem_req, stall_out} !== 5'b11000) begin errs++; $display("FAIL mis_trap got mf=%b v=%b rw=%b req=%b st=%b want 1 1 0 0 0", misalign_fault, wb_valid, wb_reg_write, dmem_req, stall_out); end
    tick();
    vecs++; if ({misalign_fault, wb_valid} !== 2'b00) begin errs++; $display("FAIL mis_pulse got mf=%b v=%b want 0 0", misalign_fault, wb_valid); end
`else
    vecs++; if ({dmem_req, dmem_addr, dmem_be, misalign_fault} !== {1'b1, 32'h100, 4'b1111, 1'b0}) begin errs++; $display("FAIL mis_align got req=%b addr=%h be=%b mf=%b want 1 00000100 1111 0", dmem_req, dmem_addr, dmem_be, misalign_fault); end
    dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
    tick();
    dmem_ack = 1'b0;
    vecs++; if ({wb_valid, wb_data, misalign_fault} !== {1'b1, 32'h1234_5678, 1'b0}) begin errs++; $display("FAIL mis_done got v=%b d=%h mf=%b want 1 12345678 0", wb_valid, wb_data, misalign_fault); end
`endif
  endtask

  task automatic test_back_to_back();
    issue(4'b0011, 32'h0000_0300, '0, 5'd10, 1'b1);
    tick();
    issue(4'b1001, 32'h0000_0402, 32'h0000_1234, 5'd11, 1'b1);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_BABE;
    tick();
    dmem_ack = 1'b0;
    vecs++; if ({wb_valid, wb_data, dmem_req, dmem_we, dmem_addr} !== {1'b1, 32'hCAFE_BABE, 1'b0, 1'b0, 32'h300}) begin errs++; $display("FAIL b2b_first got v=%b d=%h req=%b we=%b addr=%h want 1 cafebabe 0 0 00000300", wb_valid, wb_data, dmem_req, dmem_we, dmem_addr); end
    tick();
    ex_valid = 1'b0;
    vecs++; if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_valid} !== {1'b1, 1'b1, 32'h400, 4'b1100, 32'h1234_1234, 1'b0}) begin errs++; $display("FAIL b2b_second got req=%b we=%b addr=%h be=%b wd=%h v=%b want 1 1 00000400 1100 12341234 0", dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_valid); end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    vecs++; if ({wb_valid, wb_reg_write} !== 2'b10) begin errs++; $display("FAIL b2b_store got v=%b rw=%b want 1 0", wb_valid, wb_reg_write); end
  endtask

  task automatic test_halt();
    issue(4'b0011, 32'h0000_0500, '0, 5'd12, 1'b1);
    tick();
    ex_valid = 1'b0; halt = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      tick();
      vecs++; if ({dmem_req, dmem_addr, dmem_be, stall_out, wb_valid} !== {1'b1, 32'h500, 4'b1111, 1'b1, 1'b0}) begin errs++; $display("FAIL halt_hold%0d got req=%b addr=%h be=%b st=%b v=%b want 1 00000500 1111 1 0", i, dmem_req, dmem_addr, dmem_be, stall_out, wb_valid); end
    end
    halt = 1'b0;
    tick();
    dmem_ack = 1'b0;
    vecs++; if ({wb_valid, wb_data, stall_out, dmem_req} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin errs++; $display("FAIL halt_done got v=%b d=%h st=%b req=%b want 1 deadbeef 0 0", wb_valid, wb_data, stall_out, dmem_req); end
  endtask

  task automatic test_reset_mid_wait();
    issue(4'b0001, 32'h0000_0600, '0, 5'd13, 1'b1);
    tick();
    ex_valid = 1'b0;
    vecs++; if ({dmem_req, stall_out} !== 2'b11) begin errs++; $display("FAIL rst_pre got req=%b st=%b want 1 1", dmem_req, stall_out); end
    #2 rst_n = 1'b0;
    #1;
    vecs++; if ({dmem_req, stall_out} !== 2'b00) begin errs++; $display("FAIL rst_async got req=%b st=%b want 0 0", dmem_req, stall_out); end
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    vecs++; if ({wb_valid, dmem_req, stall_out} !== 3'b000) begin errs++; $display("FAIL rst_abandon got v=%b req=%b st=%b want 0 0 0", wb_valid, dmem_req, stall_out); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lb_wait();
    test_lhu_zero_wait();
    test_load_ext();
    test_sb();
    test_misalign();
    test_back_to_back();
    test_halt();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
